// File: rtl/flash_cmd_sequencer.sv
// Expands one high-level flash operation into a scripted series of low-level
// command codes, pacing them with finish handshakes, an inter-command gap and a timeout.
module flash_cmd_sequencer #(
  parameter logic [7:0]  CMD_RD_ID   = 8'd1,
  parameter logic [7:0]  CMD_WR_EN   = 8'd2,
  parameter logic [7:0]  CMD_WR_DS   = 8'd3,
  parameter logic [7:0]  CMD_PAGE_WR = 8'd4,
  parameter logic [7:0]  CMD_SET_X4  = 8'd5,
  parameter logic [7:0]  CMD_RD_MEM  = 8'd6,
  parameter int unsigned GAP_CYC     = 2,
  parameter logic [23:0] TIMEOUT     = 24'd1_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       op_vld,
  input  logic [1:0] op_code,
  output logic       op_ready,
  output logic       cmd_vld,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  input  logic       cmd_finish,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_step
);

  localparam int unsigned GAP_W  = 4;
  localparam int unsigned TCNT_W = 24;
  localparam int unsigned STEP_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [STEP_W-1:0]   step;
  logic [TCNT_W-1:0]   tcnt;
  logic [GAP_W-1:0]    gcnt;

  // Command code for a given operation and step index.
  function automatic logic [7:0] script_code(input logic [1:0] op, input logic [STEP_W-1:0] idx);
    logic [7:0] code;
    code = CMD_RD_ID;
    unique case (op)
      2'd0: code = CMD_RD_ID;
      2'd1: begin
        unique case (idx)
          3'd0:    code = CMD_WR_EN;
          3'd1:    code = CMD_PAGE_WR;
          default: code = CMD_WR_DS;
        endcase
      end
      2'd2: code = (idx == 3'd0) ? CMD_SET_X4 : CMD_RD_MEM;
      default: begin
        unique case (idx)
          3'd0:    code = CMD_WR_EN;
          3'd1:    code = CMD_PAGE_WR;
          3'd2:    code = CMD_WR_DS;
          3'd3:    code = CMD_SET_X4;
          default: code = CMD_RD_MEM;
        endcase
      end
    endcase
    return code;
  endfunction

  function automatic logic [STEP_W-1:0] last_step(input logic [1:0] op);
    logic [STEP_W-1:0] ls;
    unique case (op)
      2'd0:    ls = 3'd0;
      2'd1:    ls = 3'd2;
      2'd2:    ls = 3'd1;
      default: ls = 3'd4;
    endcase
    return ls;
  endfunction

  // Sequencer FSM; everything holds while clk_en is low.
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= S_IDLE;
      op_ready <= 1'b1;
      cmd_vld  <= 1'b0;
      cmd_data <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_step <= 3'd0;
      op_q     <= 2'd0;
      step     <= 3'd0;
      tcnt     <= '0;
      gcnt     <= '0;
    end else if (clk_en) begin
      unique case (state)
        S_IDLE: begin
          if (op_vld) begin
            op_q     <= op_code;
            step     <= 3'd0;
            err      <= 1'b0;
            err_step <= 3'd0;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            cmd_vld  <= 1'b1;
            cmd_data <= script_code(op_code, 3'd0);
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_vld <= 1'b0;
            tcnt    <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Finish has priority over a coincident timeout.
          if (cmd_finish) begin
            if (step == last_step(op_q)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              step  <= step + 3'd1;
              gcnt  <= GAP_W'(GAP_CYC - 1);
              state <= S_GAP;
            end
          end else if ((TIMEOUT != 24'd0) && (tcnt == TIMEOUT - 24'd1)) begin
            err      <= 1'b1;
            err_step <= step;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 24'd1;
          end
        end
        S_GAP: begin
          if (gcnt == '0) begin
            cmd_vld  <= 1'b1;
            cmd_data <= script_code(op_q, step);
            state    <= S_ISSUE;
          end else begin
            gcnt <= gcnt - 4'd1;
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          op_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer: drivers push expected codes and
// completions into queues, an independent monitor pops and compares them.
module tb_flash_cmd_sequencer;

  localparam int unsigned GAP_CYC = 2;

  logic       clock;
  logic       rst;
  logic       clk_en;
  logic       op_vld;
  logic [1:0] op_code;
  logic       op_ready;
  logic       cmd_vld;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       cmd_finish;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] err_step;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc;
  int done_cyc;
  bit toggle = 0;

  logic [7:0] cmd_q[$];
  logic [3:0] done_q[$];

  flash_cmd_sequencer #(.GAP_CYC(GAP_CYC), .TIMEOUT(24'd20)) dut (
    .clock(clock), .rst(rst), .clk_en(clk_en), .op_vld(op_vld), .op_code(op_code),
    .op_ready(op_ready), .cmd_vld(cmd_vld), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cmd_finish(cmd_finish), .busy(busy), .done(done), .err(err), .err_step(err_step)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // 50% clock-enable pattern when toggle is set.
  initial forever begin
    @(posedge clock);
    #1;
    if (toggle) clk_en = ~clk_en;
    else clk_en = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_code(input int op, input int i);
    case (op)
      0: return 8'd1;
      1: case (i) 0: return 8'd2; 1: return 8'd4; default: return 8'd3; endcase
      2: return (i == 0) ? 8'd5 : 8'd6;
      default: case (i) 0: return 8'd2; 1: return 8'd4; 2: return 8'd3; 3: return 8'd5; default: return 8'd6; endcase
    endcase
  endfunction

  function automatic int exp_len(input int op);
    case (op) 0: return 1; 1: return 3; 2: return 2; default: return 5; endcase
  endfunction

  // Scoreboard monitor.
  initial forever begin
    @(negedge clock);
    if (!rst) begin
      if (cmd_vld) begin
        if (cmd_q.size() == 0) check("cmd_unexpected", 32'(cmd_data), 32'hFFFF_FFFF);
        else begin
          check("cmd_data", 32'(cmd_data), 32'(cmd_q[0]));
          if (cmd_ready && clk_en) void'(cmd_q.pop_front());
        end
      end
      if (done && clk_en) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else begin
          check("done_err", 32'(err), 32'(done_q[0][3]));
          check("done_err_step", 32'(err_step), 32'(done_q[0][2:0]));
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until one enabled edge has been taken.
  task automatic en_tick();
    bit e;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      e = clk_en;
      tick();
      if (e) return;
    end
    check("en_tick_bound", 32'd0, 32'd1);
  endtask

  task automatic accept(input int op);
    bit a;
    op_vld  = 1'b1;
    op_code = 2'(op);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      a = op_ready && clk_en;
      tick();
      if (a) begin
        op_vld  = 1'b0;
        acc_cyc = cyc;
        return;
      end
    end
    op_vld = 1'b0;
    check("accept_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_hs();
    bit h;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      h = cmd_vld && cmd_ready && clk_en;
      tick();
      if (h) return;
    end
    check("handshake_bound", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int op, input bit stall, input int fin_dly,
                        input int to_step, input bit noise, input int rst_step);
    int len;
    int n;
    len = exp_len(op);
    accept(op);
    cmd_q.push_back(exp_code(op, 0));
    check("acc_cmd_vld", 32'(cmd_vld), 32'd1);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_op_ready", 32'(op_ready), 32'd0);
    for (int s = 0; s < len; s++) begin
      cmd_finish = noise;
      if (stall) begin
        cmd_ready = 1'b0;
        repeat ($urandom_range(4, 0)) en_tick();
      end
      cmd_ready = 1'b1;
      wait_hs();
      cmd_ready  = 1'b0;
      cmd_finish = 1'b0;
      if (s == rst_step) begin
        en_tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_vld", 32'(cmd_vld), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        check("rst_done_after", 32'(done), 32'd0);
        return;
      end
      if (s == to_step) begin
        done_q.push_back({1'b1, 3'(s)});
        n = 0;
        while (!done && n < 100) begin
          en_tick();
          n++;
        end
        check("timeout_cycles", 32'(n), 32'd20);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_err_step", 32'(err_step), 32'(s));
        check("timeout_cmd_vld", 32'(cmd_vld), 32'd0);
        en_tick();
        check("timeout_idle", 32'(op_ready), 32'd1);
        check("timeout_no_cmd", 32'(cmd_vld), 32'd0);
        return;
      end
      repeat (fin_dly - 1) en_tick();
      if (s == len - 1) done_q.push_back(4'b0000);
      cmd_finish = 1'b1;
      en_tick();
      cmd_finish = 1'b0;
      if (s == len - 1) begin
        done_cyc = cyc;
        check("last_done", 32'(done), 32'd1);
        check("last_err", 32'(err), 32'd0);
        en_tick();
        check("done_pulse_end", 32'(done), 32'd0);
        check("ready_after_done", 32'(op_ready), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
      end else begin
        check("gap_cmd_vld_low", 32'(cmd_vld), 32'd0);
        n = 0;
        while (!cmd_vld && n < 50) begin
          cmd_finish = noise && (n == 0);
          en_tick();
          n++;
        end
        cmd_finish = 1'b0;
        check("gap_cycles", 32'(n), 32'(GAP_CYC));
        cmd_q.push_back(exp_code(op, s + 1));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; op_vld = 1'b0; op_code = 2'd0;
    cmd_ready = 1'b0; cmd_finish = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_op_ready", 32'(op_ready), 32'd1);
    check("reset_cmd_vld", 32'(cmd_vld), 32'd0);
    check("reset_cmd_data", 32'(cmd_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_err_step", 32'(err_step), 32'd0);

    // Stray finish while idle.
    cmd_finish = 1'b1;
    en_tick();
    cmd_finish = 1'b0;
    check("idle_finish_busy", 32'(busy), 32'd0);
    check("idle_finish_cmd_vld", 32'(cmd_vld), 32'd0);

    // ID: accept edge N, handshake N+1, finish N+4, done visible right after edge N+4.
    run_op(0, 1'b0, 3, -1, 1'b0, -1);
    check("id_done_latency", 32'(done_cyc - acc_cyc), 32'd4);

    run_op(3, 1'b1, 2, -1, 1'b1, -1);
    run_op(2, 1'b0, 1, 1, 1'b0, -1);
    run_op(0, 1'b0, 2, -1, 1'b0, -1);

    toggle = 1'b1;
    run_op(1, 1'b0, 2, -1, 1'b0, -1);
    toggle = 1'b0;
    repeat (2) tick();

    run_op(1, 1'b0, 2, -1, 1'b0, 1);
    run_op(0, 1'b0, 3, -1, 1'b0, -1);

    repeat (3) tick();
    check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
